// File: rtl/mms_mem_arbiter_if.sv
// rtl/mms_mem_arbiter_if.sv - requester and memory-port signal bundle for mms_mem_arbiter
interface mms_mem_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) ();
    // Requester side
    logic [NREQ-1:0]              req_i;
    logic [NREQ-1:0]              we_i;
    logic [NREQ*ADDR_W-1:0]       addr_i;
    logic [NREQ*BEATS*DATA_W-1:0] wdata_i;
    logic [NREQ-1:0]              gnt_o;
    logic [NREQ-1:0]              done_o;
    logic [BEATS*DATA_W-1:0]      rdata_o;

    // Memory side
    logic                         mem_req_o;
    logic                         mem_we_o;
    logic [ADDR_W-1:0]            mem_addr_o;
    logic [DATA_W-1:0]            mem_wdata_o;
    logic                         mem_ready_i;
    logic                         mem_rvalid_i;
    logic [DATA_W-1:0]            mem_rdata_i;

    // The arbiter itself
    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output gnt_o, done_o, rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    // Whoever drives requests and models the memory
    modport master (
        output req_i, we_i, addr_i, wdata_i,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  gnt_o, done_o, rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mms_mem_arbiter.sv
// rtl/mms_mem_arbiter.sv - round-robin line-transfer arbiter and burst sequencer for the MMS caches
module mms_mem_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    mms_mem_arbiter_if.slave bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BEATS + 1);
    localparam int LW = BEATS * DATA_W;

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t            state;
    logic [OW-1:0]     owner;
    logic [OW-1:0]     rr_ptr;
    logic              we_q;
    logic [ADDR_W-1:0] base;
    logic [CW-1:0]     issue_cnt;
    logic [CW-1:0]     resp_cnt;
    logic [LW-1:0]     line_buf;

    logic              found;
    logic [OW-1:0]     pick;
    logic [OW-1:0]     sel_r;
    logic [CW-1:0]     sel_k;
    logic [CW-1:0]     issue_nxt;
    logic              last_issue;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_base;
    logic [DATA_W-1:0] sel_word;
    logic [ADDR_W-1:0] next_addr;
    logic              accept;
    logic              rv_take;
    logic [LW-1:0]     line_nxt;

    assign issue_nxt  = issue_cnt + CW'(1);
    assign last_issue = (issue_nxt == CW'(BEATS));
    assign next_addr  = base + ({{(ADDR_W-CW){1'b0}}, issue_nxt} << 2);
    assign accept     = bus.mem_req_o && bus.mem_ready_i;
    // Only returns for beats already issued count; writes never collect data.
    assign rv_take    = bus.mem_rvalid_i && !we_q && (resp_cnt < issue_cnt);

    // Round-robin search: first requester at or above rr_ptr, else the lowest below it.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req_i[j] && (OW'(j) >= rr_ptr)) begin
                found = 1'b1;
                pick  = OW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req_i[j]) begin
                found = 1'b1;
                pick  = OW'(j);
            end
        end
    end

    // Select the next beat's write word: word 0 of the new owner in IDLE, else the following word.
    always_comb begin
        sel_r     = (state == IDLE) ? pick : owner;
        sel_k     = (state == IDLE || last_issue) ? '0 : issue_nxt;
        sel_word  = '0;
        pick_we   = 1'b0;
        pick_base = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (pick == OW'(r)) begin
                pick_we   = bus.we_i[r];
                pick_base = bus.addr_i[r*ADDR_W +: ADDR_W] & {{(ADDR_W-4){1'b1}}, 4'b0000};
            end
            for (int k = 0; k < BEATS; k++) begin
                if (sel_r == OW'(r) && sel_k == CW'(k)) begin
                    sel_word = bus.wdata_i[(r*BEATS + k)*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Line buffer with the current read return merged into slot resp_cnt.
    always_comb begin
        line_nxt = line_buf;
        for (int k = 0; k < BEATS; k++) begin
            if (resp_cnt == CW'(k)) begin
                line_nxt[k*DATA_W +: DATA_W] = bus.mem_rdata_i;
            end
        end
    end

    // Arbitration / burst FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            owner           <= '0;
            rr_ptr          <= '0;
            we_q            <= 1'b0;
            base            <= '0;
            issue_cnt       <= '0;
            resp_cnt        <= '0;
            line_buf        <= '0;
            bus.gnt_o       <= '0;
            bus.done_o      <= '0;
            bus.rdata_o     <= '0;
            bus.mem_req_o   <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner           <= pick;
                        we_q            <= pick_we;
                        base            <= pick_base;
                        rr_ptr          <= (pick == OW'(NREQ-1)) ? '0 : pick + OW'(1);
                        bus.gnt_o       <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        bus.mem_req_o   <= 1'b1;
                        bus.mem_we_o    <= pick_we;
                        bus.mem_addr_o  <= pick_base;
                        bus.mem_wdata_o <= sel_word;
                        state           <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        issue_cnt <= issue_nxt;
                        if (last_issue) begin
                            bus.mem_req_o <= 1'b0;
                            bus.mem_we_o  <= 1'b0;
                            if (we_q) begin
                                bus.done_o <= bus.gnt_o;
                                state      <= DONE;
                            end
                        end else begin
                            bus.mem_addr_o  <= next_addr;
                            bus.mem_wdata_o <= sel_word;
                        end
                    end
                    if (rv_take) begin
                        line_buf <= line_nxt;
                        resp_cnt <= resp_cnt + CW'(1);
                        if (resp_cnt + CW'(1) == CW'(BEATS)) begin
                            bus.rdata_o <= line_nxt;
                            bus.done_o  <= bus.gnt_o;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    bus.done_o <= '0;
                    bus.gnt_o  <= '0;
                    issue_cnt  <= '0;
                    resp_cnt   <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mms_mem_arbiter.sv
// tb/tb_mms_mem_arbiter.sv - directed self-checking bench for mms_mem_arbiter
module tb_mms_mem_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NB   = 4;

    typedef struct {
        int           r;
        bit           we;
        logic [31:0]  addr;
        logic [127:0] line;
        int           lat;
        int           stall_at;
        int           stall_len;
        bit           stray;
        logic [31:0]  exp_base;
        logic [127:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mms_mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .BEATS(NB)) bus ();
    mms_mem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .BEATS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int          lat, acc_n, resp_n, stall_at, stall_left, last_acc, last_rv;
    bit          stray;
    logic [31:0] rd_words [4];
    int          ret_q [$];
    logic [31:0] acc_addr [$];
    logic [31:0] acc_data [$];
    bit          acc_we [$];
    logic [31:0] hold_addr [$];
    logic [31:0] hold_data [$];

    vec_t tv [5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset(input int l, input int sa, input int sl, input bit st);
        lat = l; acc_n = 0; resp_n = 0; stall_at = sa; stall_left = sl; stray = st;
        last_acc = -1; last_rv = -1;
        ret_q.delete(); acc_addr.delete(); acc_data.delete(); acc_we.delete();
        hold_addr.delete(); hold_data.delete();
    endtask

    // Memory model: drives this cycle's ready/rvalid from the DUT's registered outputs.
    task automatic mem_step();
        bus.mem_ready_i  = 1'b1;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        if (bus.mem_req_o && acc_n == stall_at && stall_left > 0) begin
            bus.mem_ready_i = 1'b0;
            stall_left--;
            hold_addr.push_back(bus.mem_addr_o);
            hold_data.push_back(bus.mem_wdata_o);
        end
        if (ret_q.size() > 0 && ret_q[0] == cyc) begin
            void'(ret_q.pop_front());
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = rd_words[resp_n % 4];
            resp_n++;
            last_rv = cyc;
        end else if (stray) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 32'hDEAD_BEEF;
        end
        if (bus.mem_req_o && bus.mem_ready_i) begin
            acc_addr.push_back(bus.mem_addr_o);
            acc_data.push_back(bus.mem_wdata_o);
            acc_we.push_back(bus.mem_we_o);
            acc_n++;
            last_acc = cyc;
            if (!bus.mem_we_o) ret_q.push_back(cyc + lat);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"},   bus.gnt_o, 0);
        chk({tag, "_done"},  bus.done_o, 0);
        chk({tag, "_rdata"}, bus.rdata_o, 0);
        chk({tag, "_mreq"},  bus.mem_req_o, 0);
        chk({tag, "_mwe"},   bus.mem_we_o, 0);
        chk({tag, "_maddr"}, bus.mem_addr_o, 0);
        chk({tag, "_mwd"},   bus.mem_wdata_o, 0);
    endtask

    task automatic run_txn(input vec_t v);
        logic [1:0]  g;
        logic [31:0] e;
        bit          seen;
        g = 2'b01 << v.r;
        bus.req_i             = '0;
        bus.req_i[v.r]        = 1'b1;
        bus.we_i[v.r]         = v.we;
        bus.addr_i[v.r*32 +: 32]   = v.addr;
        bus.wdata_i[v.r*128 +: 128] = v.line;
        for (int k = 0; k < 4; k++) rd_words[k] = v.line[k*32 +: 32];
        model_reset(v.lat, v.stall_at, v.stall_len, v.stray);
        tick();
        chk("first_gnt", bus.gnt_o, g);
        chk("first_mreq", bus.mem_req_o, 1);
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            mem_step();
            if (bus.done_o != 0) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk("done_seen", seen, 1);
        chk("done_owner", bus.done_o, g);
        chk("gnt_in_done", bus.gnt_o, g);
        chk("done_latency", cyc, (v.we ? last_acc : last_rv) + 1);
        chk("beats_accepted", acc_addr.size(), 4);
        for (int k = 0; k < acc_addr.size(); k++) begin
            e = v.exp_base + 32'(4 * k);
            chk("beat_addr", acc_addr[k], e);
            chk("beat_we", acc_we[k], v.we);
            if (v.we) chk("beat_wdata", acc_data[k], v.line[k*32 +: 32]);
        end
        chk("stall_cycles", hold_addr.size(), v.stall_len);
        for (int k = 0; k < hold_addr.size(); k++) begin
            e = v.exp_base + 32'(4 * v.stall_at);
            chk("stall_addr_hold", hold_addr[k], e);
            if (v.we) chk("stall_wdata_hold", hold_data[k], v.line[v.stall_at*32 +: 32]);
        end
        chk("rdata_line", bus.rdata_o, v.exp_rdata);
        bus.req_i = '0;
        stray     = 0;
        tick();
        mem_step();
        chk("idle_gnt", bus.gnt_o, 0);
        chk("idle_done", bus.done_o, 0);
    endtask

    initial begin
        logic [1:0] grants [$];
        logic [1:0] prev_gnt;
        int         done_cnt, last_done;

        tv[0] = '{0, 0, 32'h1000_0014, 128'h000000A3_000000A2_000000A1_000000A0, 2, -1, 0, 0,
                  32'h1000_0010, 128'h000000A3_000000A2_000000A1_000000A0};
        tv[1] = '{1, 1, 32'h0000_2000, 128'h000000D3_000000D2_000000D1_000000D0, 1, 2, 2, 1,
                  32'h0000_2000, 128'h000000A3_000000A2_000000A1_000000A0};
        tv[2] = '{1, 0, 32'hFFFF_FFF0, 128'h00000014_00000013_00000012_00000011, 1, -1, 0, 0,
                  32'hFFFF_FFF0, 128'h00000014_00000013_00000012_00000011};
        tv[3] = '{0, 1, 32'h0000_0108, 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000, 1, 0, 1, 0,
                  32'h0000_0100, 128'h00000014_00000013_00000012_00000011};
        tv[4] = '{0, 0, 32'h3000_0004, 128'hB0000003_B0000002_B0000001_B0000000, 3, 1, 1, 0,
                  32'h3000_0000, 128'hB0000003_B0000002_B0000001_B0000000};

        bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
        bus.mem_ready_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
        model_reset(1, -1, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Stray returns while idle must not move anything.
        model_reset(1, -1, 0, 1);
        repeat (3) begin
            mem_step();
            tick();
        end
        stray = 0;
        mem_step();
        chk("stray_idle_gnt", bus.gnt_o, 0);
        chk("stray_idle_mreq", bus.mem_req_o, 0);
        chk("stray_idle_done", bus.done_o, 0);
        chk("stray_idle_rdata", bus.rdata_o, 0);

        for (int i = 0; i < 4; i++) run_txn(tv[i]);

        // Both requesters held from reset: grants 0,1,0 with one idle cycle between bursts.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset(1, -1, 0, 0);
        bus.req_i  = 2'b11;
        bus.we_i   = 2'b00;
        bus.addr_i = {32'h0000_5000, 32'h0000_4000};
        prev_gnt   = '0;
        done_cnt   = 0;
        last_done  = -1;
        for (int k = 0; k < 100 && done_cnt < 3; k++) begin
            mem_step();
            chk("gnt_onehot", ($countones(bus.gnt_o) <= 1), 1);
            if (bus.gnt_o != 0 && prev_gnt == 0) begin
                grants.push_back(bus.gnt_o);
                if (last_done >= 0) chk("idle_gap", cyc, last_done + 2);
            end
            if (bus.done_o != 0) begin
                done_cnt++;
                last_done = cyc;
            end
            prev_gnt = bus.gnt_o;
            tick();
        end
        chk("rr_bursts", done_cnt, 3);
        chk("rr_grant_count", grants.size(), 3);
        if (grants.size() == 3) begin
            chk("rr_grant0", grants[0], 2'b01);
            chk("rr_grant1", grants[1], 2'b10);
            chk("rr_grant2", grants[2], 2'b01);
        end
        bus.req_i = '0;
        tick();
        tick();

        // Reset after two read beats accepted, then late returns arrive.
        bus.req_i          = 2'b01;
        bus.we_i           = 2'b00;
        bus.addr_i[31:0]   = 32'h3000_0000;
        model_reset(3, -1, 0, 0);
        tick();
        for (int k = 0; k < 20; k++) begin
            mem_step();
            if (acc_n == 2) break;
            tick();
        end
        chk("pre_reset_beats", acc_n, 2);
        tick();
        rst = 1'b1;
        mem_step();
        tick();
        rst       = 1'b0;
        bus.req_i = '0;
        check_all_zero("midreset");
        for (int k = 0; k < 4; k++) begin
            mem_step();
            chk("late_rv_done", bus.done_o, 0);
            chk("late_rv_gnt", bus.gnt_o, 0);
            chk("late_rv_mreq", bus.mem_req_o, 0);
            tick();
        end
        run_txn(tv[4]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mms_mem_arbiter.md
Name: mms_mem_arbiter

Overview:
- Shared-memory-port arbiter and burst sequencer for the MMS cache subsystem.
- Arbitrates line-sized transfers from NREQ requesters (default: 0 = I-cache refill, 1 = D-cache refill/writeback) onto one single-word memory port.
- Cache line = 4 words of 32 bits (16 B, 4-bit offset), same packing as the instruction set type (word k in bits [32k+31:32k]).
- Sequences each transfer as a BEATS-beat burst and returns the assembled line to the owner.

Parameters:
- NREQ, 2, number of requesters (2..4)
- ADDR_W, 32, address width
- DATA_W, 32, memory word width
- BEATS, 4, words per cache line

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_i  in  NREQ  transfer request per requester, held until done
- we_i  in  NREQ  1 = line write (writeback), 0 = line read (refill)
- addr_i  in  NREQ*ADDR_W  line address per requester; low 4 bits ignored
- wdata_i  in  NREQ*BEATS*DATA_W  write line per requester
- gnt_o  out  NREQ  one-hot, high while the requester owns the port
- done_o  out  NREQ  one-cycle completion pulse to the owner
- rdata_o  out  BEATS*DATA_W  assembled read line, valid with done_o
- mem_req_o  out  1  beat request valid
- mem_we_o  out  1  beat is a write
- mem_addr_o  out  ADDR_W  beat address
- mem_wdata_o  out  DATA_W  beat write data
- mem_ready_i  in  1  memory accepts the beat when mem_req_o && mem_ready_i
- mem_rvalid_i  in  1  read beat returned; returns are in order
- mem_rdata_i  in  DATA_W  read beat data

Behaviour:
- Reset values: all outputs 0; state IDLE; issue_cnt = resp_cnt = 0; rr_ptr = 0, so requester 0 has priority first.
- FSM IDLE:
  - If any req_i is set, grant one requester by round-robin, searching upward from rr_ptr with wrap.
  - Latch owner, we, and line base = addr & ~0xF.
  - Go to BURST next cycle and set gnt_o[owner] there.
  - rr_ptr <= owner+1 mod NREQ.
- Ignored in IDLE: mem_rvalid_i and mem_ready_i.
- FSM BURST, issue phase:
  - mem_req_o = (issue_cnt < BEATS).
  - mem_addr_o = base + 4*issue_cnt.
  - mem_we_o = latched we.
  - mem_wdata_o = word[issue_cnt] of wdata_i[owner].
  - issue_cnt increments on each accept.
  - Issue is pipelined: no wait for read data between beats.
- FSM BURST, read collection:
  - On each mem_rvalid_i, store mem_rdata_i into word[resp_cnt] of the line buffer and increment resp_cnt.
  - rvalid while resp_cnt == issue_cnt, or during a write, is ignored.
- BURST -> DONE when complete:
  - Read: resp_cnt reaches BEATS (the final rvalid cycle).
  - Write: final beat accepted.
- FSM DONE:
  - done_o[owner] = 1 for exactly one cycle; gnt_o still high; rdata_o = line buffer (holds value until the next read completes).
  - Clear counters, next state IDLE.
- Latency: req in cycle t produces the first mem_req_o in t+1.
  - Read: done_o one cycle after the 4th rvalid.
  - Write: done_o one cycle after the 4th accept.
  - Minimum gap between bursts: 1 IDLE cycle.
- Requester protocol: req, we, addr and wdata must be stable from req assertion until done. Dropping req mid-burst does not abort; the burst completes and done pulses anyway.
- Back-pressure: while mem_ready_i = 0, mem_req_o, mem_addr_o and mem_wdata_o hold.
- Simultaneous requests: exactly one gnt_o bit; no requester is starved (bounded by NREQ-1 bursts).
- Reset mid-burst: returns to the reset state next cycle; no done_o. Late mem_rvalid_i after reset is ignored (IDLE). Memory side is responsible for flushing.
- Address wrap: base + 4*k is computed modulo 2^ADDR_W.

Test Plan:
- Single read, requester 0, addr 0x1000_0014, memory latency 2:
  - mem_addr_o = 0x1000_0010, 0x14, 0x18, 0x1C on consecutive cycles.
  - Returned data 0xA0..0xA3 → rdata_o = {0xA3,0xA2,0xA1,0xA0}.
  - done_o[0] one cycle after the last rvalid.
- req_i = 2'b11 held for 3 bursts from reset → grants in order 0, 1, 0; one IDLE cycle between bursts; gnt_o always one-hot.
- Write from requester 1, line {0xD3,0xD2,0xD1,0xD0} at 0x2000, mem_ready_i low for 2 cycles on beat 2:
  - Beat 2 address and data hold during the stall.
  - Four beats written in order.
  - done_o[1] one cycle after the 4th accept; no read data consumed.
- rst asserted after 2 read beats accepted:
  - Outputs all 0 next cycle; no done_o.
  - A stray rvalid afterward is ignored.
  - A new request from requester 0 then completes normally.
- Stray mem_rvalid_i in IDLE and during a write burst → no state change; rdata_o unchanged.
- Read at base 0xFFFF_FFF0 → beat addresses 0xFFFF_FFF0..0xFFFF_FFFC; no carry out.
